// File: rtl/wavelet_decomposer_mp.sv
// Decimated Haar DWT cascade, LEVELS stages, per-level detail strobes.
// Define WAVELET_DECOMP_SAT_EN to clamp details and expose sat_flag.
module wavelet_decomposer_mp #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16,
  parameter int LEVELS = 4,
  parameter int SHIFT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DIN_W-1:0]         in_data,
  output logic [LEVELS*DOUT_W-1:0] d_out,
  output logic [LEVELS-1:0]        d_valid,
  output logic [DIN_W-1:0]         a_out,
  output logic                     a_valid
`ifdef WAVELET_DECOMP_SAT_EN
  ,
  output logic [LEVELS-1:0]        sat_flag
`endif
);

  localparam int RW = (DIN_W + 1 > DOUT_W) ? DIN_W + 1 : DOUT_W;

`ifdef WAVELET_DECOMP_SAT_EN
  localparam logic signed [RW-1:0] D_MAX =
    {{(RW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] D_MIN = ~D_MAX;
`endif

  logic [LEVELS-1:0]       stb;
  logic [LEVELS*DIN_W-1:0] a_bus;

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    logic                    s_in;
    logic [DIN_W-1:0]        x_in;
    logic                    phase;
    logic [DIN_W-1:0]        x0;
    logic                    stb_q;
    logic [DIN_W-1:0]        a_q;
    logic [DOUT_W-1:0]       d_q;
    logic [DIN_W:0]          sum;
    logic signed [RW-1:0]    raw;
    logic signed [RW-1:0]    d_s;
    logic [DOUT_W-1:0]       d_n;
    logic                    fire;
    logic                    load;

    if (i == 0) begin : g_src
      assign s_in = in_valid;
      assign x_in = in_data;
    end else begin : g_src
      assign s_in = stb[i-1];
      assign x_in = a_bus[(i-1)*DIN_W +: DIN_W];
    end

    assign load = !clr && s_in && !phase;
    assign fire = !clr && s_in && phase;

`ifdef WAVELET_DECOMP_SAT_EN
    logic sat_hit;
    logic sat_q;

    always_comb begin
      sum     = {1'b0, x0} + {1'b0, x_in};
      raw     = $signed(RW'(x0) - RW'(x_in));
      d_s     = raw >>> SHIFT;
      sat_hit = 1'b0;
      d_n     = DOUT_W'(d_s);
      if (d_s > D_MAX) begin
        d_n     = DOUT_W'(D_MAX);
        sat_hit = 1'b1;
      end else if (d_s < D_MIN) begin
        d_n     = DOUT_W'(D_MIN);
        sat_hit = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sat_q <= 1'b0;
      end else if (clr) begin
        sat_q <= 1'b0;
      end else if (fire && sat_hit) begin
        sat_q <= 1'b1;
      end
    end

    assign sat_flag[i] = sat_q;
`else
    always_comb begin
      sum = {1'b0, x0} + {1'b0, x_in};
      raw = $signed(RW'(x0) - RW'(x_in));
      d_s = raw >>> SHIFT;
      d_n = DOUT_W'(d_s);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        phase <= 1'b0;
        x0    <= '0;
        stb_q <= 1'b0;
        a_q   <= '0;
        d_q   <= '0;
      end else begin
        unique case (1'b1)
          clr: begin
            phase <= 1'b0;
            stb_q <= 1'b0;
          end
          load: begin
            x0    <= x_in;
            phase <= 1'b1;
            stb_q <= 1'b0;
          end
          fire: begin
            a_q   <= DIN_W'(sum >> 1);
            d_q   <= d_n;
            phase <= 1'b0;
            stb_q <= 1'b1;
          end
          default: begin
            stb_q <= 1'b0;
          end
        endcase
      end
    end

    assign stb[i]                      = stb_q;
    assign a_bus[i*DIN_W +: DIN_W]     = a_q;
    assign d_out[i*DOUT_W +: DOUT_W]   = d_q;
  end

  assign d_valid = stb;
  assign a_out   = a_bus[(LEVELS-1)*DIN_W +: DIN_W];
  assign a_valid = stb[LEVELS-1];

endmodule
